// File: rtl/pipe_stage_skid.sv
// Pipeline register stage with a one-entry skid buffer.
// Holds up to two beats (main, skid) so that upstream can be told "not ready"
// one cycle late without losing data. stall freezes both sides; flush empties
// the stage and counts what it threw away in a saturating 16-bit counter.
module pipe_stage_skid #(
  parameter int                DATA_W      = 96,
  parameter int                CTRL_W      = 16,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [15:0]       drop_count
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [CTRL_W-1:0]   main_ctrl_reg, main_ctrl_next;
  logic [DATA_W-1:0]   main_data_reg, main_data_next;
  logic [CTRL_W-1:0]   skid_ctrl_reg, skid_ctrl_next;
  logic [DATA_W-1:0]   skid_data_reg, skid_data_next;
  logic [15:0]         drop_count_reg, drop_count_next;

  logic                accept;
  logic                emit;
  logic [16:0]         drop_sum;

  // Handshake outputs; stall hides both sides so no transfer can happen.
  always_comb begin
    in_ready  = (state_reg != ST_FULL) && !stall;
    out_valid = (state_reg != ST_EMPTY) && !stall;
    out_ctrl  = out_valid ? main_ctrl_reg : BUBBLE_CTRL;
    out_data  = main_data_reg;
    accept    = in_valid && in_ready && !flush;
    emit      = out_valid && out_ready && !flush;
  end

  // Occupancy is a direct decode of the state.
  always_comb begin
    occupancy = 2'd0;
    case (state_reg)
      ST_ONE:  occupancy = 2'd1;
      ST_FULL: occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  assign drop_count = drop_count_reg;

  // Beats lost on a flush: everything held plus the beat on the input.
  assign drop_sum = {1'b0, drop_count_reg} + {15'd0, occupancy} + {16'd0, in_valid};

  // Next-state, payload and counter logic; flush overrides everything else.
  always_comb begin
    state_next      = state_reg;
    main_ctrl_next  = main_ctrl_reg;
    main_data_next  = main_data_reg;
    skid_ctrl_next  = skid_ctrl_reg;
    skid_data_next  = skid_data_reg;
    drop_count_next = drop_count_reg;

    if (flush) begin
      state_next      = ST_EMPTY;
      main_ctrl_next  = '0;
      main_data_next  = '0;
      skid_ctrl_next  = '0;
      skid_data_next  = '0;
      drop_count_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (accept) begin
            state_next     = ST_ONE;
            main_ctrl_next = in_ctrl;
            main_data_next = in_data;
          end
        end
        ST_ONE: begin
          if (accept && emit) begin
            main_ctrl_next = in_ctrl;
            main_data_next = in_data;
          end else if (accept) begin
            state_next     = ST_FULL;
            skid_ctrl_next = in_ctrl;
            skid_data_next = in_data;
          end else if (emit) begin
            state_next = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the drain side can move.
          if (emit) begin
            state_next     = ST_ONE;
            main_ctrl_next = skid_ctrl_reg;
            main_data_next = skid_data_reg;
          end
        end
        default: begin
          state_next = ST_EMPTY;
        end
      endcase
    end
  end

  // State and payload registers; reset wins over flush and loses contents uncounted.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_EMPTY;
      main_ctrl_reg  <= '0;
      main_data_reg  <= '0;
      skid_ctrl_reg  <= '0;
      skid_data_reg  <= '0;
      drop_count_reg <= '0;
    end else begin
      state_reg      <= state_next;
      main_ctrl_reg  <= main_ctrl_next;
      main_data_reg  <= main_data_next;
      skid_ctrl_reg  <= skid_ctrl_next;
      skid_data_reg  <= skid_data_next;
      drop_count_reg <= drop_count_next;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: a vector table for the single-cycle
// behaviour plus a hand sequence for drop_count saturation and reset.
module tb_pipe_stage_skid;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 8;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              stall;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [15:0]       drop_count;

  int total;
  int bad;

  pipe_stage_skid #(
    .DATA_W(DATA_W),
    .CTRL_W(CTRL_W),
    .BUBBLE_CTRL(8'h00)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_ctrl(in_ctrl),
    .in_data(in_data),
    .stall(stall),
    .flush(flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl(out_ctrl),
    .out_data(out_data),
    .occupancy(occupancy),
    .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One row: inputs driven for one cycle, and the outputs expected during
  // that cycle (state before the edge, combined with these inputs).
  typedef struct {
    logic        rst;
    logic        iv;
    logic [7:0]  ictrl;
    logic [31:0] idata;
    logic        stl;
    logic        fl;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [7:0]  e_octrl;
    logic [31:0] e_odata;
    logic [1:0]  e_occ;
    logic [15:0] e_dc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic iv, input logic [7:0] ictrl,
                     input logic [31:0] idata, input logic stl, input logic fl,
                     input logic ordy, input logic e_ir, input logic e_ov,
                     input logic [7:0] e_octrl, input logic [31:0] e_odata,
                     input logic [1:0] e_occ, input logic [15:0] e_dc);
    vec_t v;
    v.rst = rst; v.iv = iv; v.ictrl = ictrl; v.idata = idata;
    v.stl = stl; v.fl = fl; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_octrl = e_octrl; v.e_odata = e_odata;
    v.e_occ = e_occ; v.e_dc = e_dc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string tag, input int idx, input string field,
                     input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s[%0d] %s: got 0x%0h want 0x%0h", tag, idx, field, got, want);
    end
  endtask

  task automatic check_all(input string tag, input int idx, input logic e_ir,
                           input logic e_ov, input logic [7:0] e_octrl,
                           input logic [31:0] e_odata, input logic [1:0] e_occ,
                           input logic [15:0] e_dc);
    chk(tag, idx, "in_ready",   {31'd0, in_ready},   {31'd0, e_ir});
    chk(tag, idx, "out_valid",  {31'd0, out_valid},  {31'd0, e_ov});
    chk(tag, idx, "out_ctrl",   {24'd0, out_ctrl},   {24'd0, e_octrl});
    chk(tag, idx, "out_data",   out_data,            e_odata);
    chk(tag, idx, "occupancy",  {30'd0, occupancy},  {30'd0, e_occ});
    chk(tag, idx, "drop_count", {16'd0, drop_count}, {16'd0, e_dc});
    $display("%s[%0d] ir=%0b ov=%0b ctrl=%02h data=%08h occ=%0d drops=%0d", tag, idx,
             in_ready, out_valid, out_ctrl, out_data, occupancy, drop_count);
  endtask

  task automatic drive(input logic rst, input logic iv, input logic [7:0] c,
                       input logic [31:0] d, input logic stl, input logic fl,
                       input logic ordy);
    reset = rst; in_valid = iv; in_ctrl = c; in_data = d;
    stall = stl; flush = fl; out_ready = ordy;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    drive(1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0);

    //   rst iv ctrl   data      stl fl ordy | ir ov octrl odata   occ dc
    // reset state, idle
    add(0, 0, 8'h00, 32'h00, 0, 0, 1,  1, 0, 8'h00, 32'h00, 0, 0);
    // streaming 1..4 with out_ready high
    add(0, 1, 8'h11, 32'h01, 0, 0, 1,  1, 0, 8'h00, 32'h00, 0, 0);
    add(0, 1, 8'h12, 32'h02, 0, 0, 1,  1, 1, 8'h11, 32'h01, 1, 0);
    add(0, 1, 8'h13, 32'h03, 0, 0, 1,  1, 1, 8'h12, 32'h02, 1, 0);
    add(0, 1, 8'h14, 32'h04, 0, 0, 1,  1, 1, 8'h13, 32'h03, 1, 0);
    add(0, 0, 8'h00, 32'h00, 0, 0, 1,  1, 1, 8'h14, 32'h04, 1, 0);
    add(0, 0, 8'h00, 32'h00, 0, 0, 1,  1, 0, 8'h00, 32'h04, 0, 0);
    // backpressure: fill to FULL, then drain A then B
    add(0, 1, 8'h21, 32'h0A, 0, 0, 0,  1, 0, 8'h00, 32'h04, 0, 0);
    add(0, 1, 8'h22, 32'h0B, 0, 0, 0,  1, 1, 8'h21, 32'h0A, 1, 0);
    add(0, 0, 8'h00, 32'h00, 0, 0, 0,  0, 1, 8'h21, 32'h0A, 2, 0);
    add(0, 0, 8'h00, 32'h00, 0, 0, 1,  0, 1, 8'h21, 32'h0A, 2, 0);
    add(0, 0, 8'h00, 32'h00, 0, 0, 1,  1, 1, 8'h22, 32'h0B, 1, 0);
    add(0, 0, 8'h00, 32'h00, 0, 0, 1,  1, 0, 8'h00, 32'h0B, 0, 0);
    // flush while FULL with a beat on the input: three drops
    add(0, 1, 8'h31, 32'h31, 0, 0, 0,  1, 0, 8'h00, 32'h0B, 0, 0);
    add(0, 1, 8'h32, 32'h32, 0, 0, 0,  1, 1, 8'h31, 32'h31, 1, 0);
    add(0, 1, 8'h33, 32'h33, 0, 1, 0,  0, 1, 8'h31, 32'h31, 2, 0);
    add(0, 0, 8'h00, 32'h00, 0, 0, 0,  1, 0, 8'h00, 32'h00, 0, 3);
    // flush when empty with no input beat drops nothing
    add(0, 0, 8'h00, 32'h00, 0, 1, 0,  1, 0, 8'h00, 32'h00, 0, 3);
    add(0, 0, 8'h00, 32'h00, 0, 0, 0,  1, 0, 8'h00, 32'h00, 0, 3);
    // stall while ONE holding 0x5A: frozen for 3 cycles, 0x5A leaves first
    add(0, 1, 8'h5A, 32'h5A, 0, 0, 0,  1, 0, 8'h00, 32'h00, 0, 3);
    add(0, 1, 8'h60, 32'h60, 1, 0, 1,  0, 0, 8'h00, 32'h5A, 1, 3);
    add(0, 1, 8'h60, 32'h60, 1, 0, 1,  0, 0, 8'h00, 32'h5A, 1, 3);
    add(0, 1, 8'h60, 32'h60, 1, 0, 1,  0, 0, 8'h00, 32'h5A, 1, 3);
    add(0, 1, 8'h60, 32'h60, 0, 0, 1,  1, 1, 8'h5A, 32'h5A, 1, 3);
    add(0, 0, 8'h00, 32'h00, 0, 0, 1,  1, 1, 8'h60, 32'h60, 1, 3);
    // flush beats stall: ONE + input beat -> two drops
    add(0, 1, 8'h70, 32'h70, 0, 0, 0,  1, 0, 8'h00, 32'h60, 0, 3);
    add(0, 1, 8'h71, 32'h71, 1, 1, 0,  0, 0, 8'h00, 32'h70, 1, 3);
    add(0, 0, 8'h00, 32'h00, 0, 0, 0,  1, 0, 8'h00, 32'h00, 0, 5);
    // reset beats flush: contents lost, counter cleared, nothing counted
    add(0, 1, 8'h80, 32'h80, 0, 0, 0,  1, 0, 8'h00, 32'h00, 0, 5);
    add(1, 1, 8'h81, 32'h81, 0, 1, 0,  1, 1, 8'h80, 32'h80, 1, 5);
    add(0, 0, 8'h00, 32'h00, 0, 0, 0,  1, 0, 8'h00, 32'h00, 0, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b1);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].iv, vecs[i].ictrl, vecs[i].idata,
            vecs[i].stl, vecs[i].fl, vecs[i].ordy);
      #1;
      check_all("vec", i, vecs[i].e_ir, vecs[i].e_ov, vecs[i].e_octrl,
                vecs[i].e_odata, vecs[i].e_occ, vecs[i].e_dc);
    end

    // Saturation: each flush cycle in EMPTY with a beat present drops one.
    @(negedge clk);
    drive(1'b0, 1'b1, 8'h00, 32'h0, 1'b0, 1'b1, 1'b0);
    repeat (65534) @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    check_all("sat", 0, 1'b1, 1'b0, 8'h00, 32'h0, 2'd0, 16'hFFFE);

    @(negedge clk);
    drive(1'b0, 1'b1, 8'h91, 32'h91, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b1, 8'h92, 32'h92, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b1, 8'h93, 32'h93, 1'b0, 1'b1, 1'b0);
    #1;
    check_all("sat", 1, 1'b0, 1'b1, 8'h91, 32'h91, 2'd2, 16'hFFFE);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    check_all("sat", 2, 1'b1, 1'b0, 8'h00, 32'h0, 2'd0, 16'hFFFF);

    // Further flushes stay pinned at the ceiling.
    @(negedge clk);
    drive(1'b0, 1'b1, 8'h00, 32'h0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    check_all("sat", 3, 1'b1, 1'b0, 8'h00, 32'h0, 2'd0, 16'hFFFF);

    // Reset clears the counter.
    @(negedge clk);
    drive(1'b0, 1'b1, 8'hA1, 32'hA1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    check_all("rst", 0, 1'b1, 1'b0, 8'h00, 32'h0, 2'd0, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 The block SHALL have parameter DATA_W, default 96, meaning width of the data payload (operands, PC, immediate).
REQ-002 The block SHALL have parameter CTRL_W, default 16, meaning width of the control payload (write-enable and mux selects).
REQ-003 The block SHALL have parameter BUBBLE_CTRL, default 0, meaning the control value presented whenever no valid entry is output.
REQ-004 The block SHALL have port clk, input, 1, the clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port in_valid, input, 1, upstream beat present.
REQ-007 The block SHALL have port in_ready, output, 1, block can accept a beat.
REQ-008 The block SHALL have ports in_ctrl, input, CTRL_W, and in_data, input, DATA_W, the upstream payload.
REQ-009 The block SHALL have port stall, input, 1, hazard hold that freezes both sides.
REQ-010 The block SHALL have port flush, input, 1, discards all held entries and the current input beat.
REQ-011 The block SHALL have port out_valid, output, 1, downstream beat present.
REQ-012 The block SHALL have port out_ready, input, 1, downstream accepts a beat.
REQ-013 The block SHALL have ports out_ctrl, output, CTRL_W, and out_data, output, DATA_W, the downstream payload.
REQ-014 The block SHALL have port occupancy, output, 2, entries held: 0, 1 or 2.
REQ-015 The block SHALL have port drop_count, output, 16, saturating count of beats discarded by flush.

Function
REQ-016 The block SHALL hold two entries, main and skid, with states EMPTY, ONE (main valid) and FULL (main and skid valid).
REQ-017 The block SHALL drive in_ready = (state != FULL) && !stall, out_valid = (state != EMPTY) && !stall, and out_data = main data.
REQ-018 The block SHALL drive out_ctrl = main ctrl when out_valid=1, else BUBBLE_CTRL.
REQ-019 The block SHALL define accept = in_valid && in_ready && !flush and emit = out_valid && out_ready && !flush.
REQ-020 In EMPTY, the block SHALL go to ONE and load main on accept; otherwise it SHALL remain in EMPTY.
REQ-021 In ONE, the block SHALL: on accept and emit, load main and stay in ONE; on accept only, load skid and go to FULL; on emit only, go to EMPTY; otherwise hold.
REQ-022 In FULL, the block SHALL copy skid into main and go to ONE on emit; otherwise it SHALL hold.
REQ-023 The block SHALL deliver beats in acceptance order, with 1-cycle latency from accept to out_valid when EMPTY and sustained throughput of 1 beat per cycle with out_ready held high.
REQ-024 When stall=1 and flush=0, the block SHALL change no state, payload or counter.
REQ-025 Flush SHALL take priority over stall, accept and emit: next state is EMPTY, main and skid data are zeroed, and occupancy becomes 0.
REQ-026 On flush, drop_count SHALL increase by occupancy plus (in_valid ? 1 : 0) and saturate at 0xFFFF.
REQ-027 Occupancy SHALL equal 0, 1 and 2 for EMPTY, ONE and FULL respectively.

Reset
REQ-028 While reset=1 at a clock edge, the block SHALL go to EMPTY, zero main and skid data, and clear drop_count, giving in_ready=1 (if stall=0), out_valid=0, out_ctrl=BUBBLE_CTRL, out_data=0 and occupancy=0.
REQ-029 Reset SHALL take priority over flush, stall and all transfers, and any mid-operation contents SHALL be lost without being counted as drops.

Verification (DATA_W=32, CTRL_W=8, BUBBLE_CTRL=0)
REQ-030 Streaming: out_ready=1, beats D=1..4 on consecutive cycles -> out_data 1,2,3,4 one cycle later each; occupancy stays 1; in_ready stays 1.
REQ-031 Backpressure: out_ready=0, beats 0xA, 0xB -> occupancy 2, in_ready=0, out_data=0xA; then out_ready=1 -> 0xA, then 0xB on consecutive cycles.
REQ-032 Flush when FULL with in_valid=1 -> next cycle out_valid=0, out_ctrl=0x00, out_data=0, drop_count=3, in_ready=1.
REQ-033 Stall while ONE holding ctrl=0x5A, with out_ready=1 and in_valid=1 for 3 cycles -> out_valid=0, out_ctrl=0x00, nothing accepted or emitted; after stall drops, 0x5A is emitted first.
REQ-034 drop_count preset to 0xFFFE via flushes, then flush while FULL -> drop_count=0xFFFF; then reset -> 0x0000, occupancy 0.
